// File: rtl/md5_window_scheduler.sv
// Slides a STR_LEN-byte window over one text block, hands each window to a
// single md5 core and records the offset of the first window whose digest matches.
module md5_window_scheduler #(
  parameter int STR_LEN = 19,
  parameter int LEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [127:0]         target_hash,
  input  logic                 start,
  input  logic [LEN_W-1:0]     byte_count,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 md5_start,
  output logic [STR_LEN*8-1:0] md5_msg,
  input  logic                 md5_busy,
  input  logic                 md5_done,
  input  logic [127:0]         md5_digest,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic [LEN_W-1:0]     match_offset
);

  // state  | meaning
  // IDLE   | waiting for start
  // FILL   | loading the first STR_LEN bytes (or a whole short block)
  // ISSUE  | window complete, waiting for the core to accept md5_start
  // WAIT   | hash in flight, waiting for md5_done
  // SHIFT  | taking one more byte to advance the window
  // DRAIN  | match found, discarding the rest of the block
  // DONE   | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_SHIFT, S_DRAIN, S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] WIN_LEN = LEN_W'(STR_LEN);

  state_t               state_q, state_d;
  logic [127:0]         tgt_q, tgt_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     rx_q, rx_d;
  logic [STR_LEN*8-1:0] win_q, win_d;
  logic                 match_q, match_d;
  logic [LEN_W-1:0]     off_q, off_d;

  logic                 xfer;
  logic [LEN_W-1:0]     rx_inc;
  logic [STR_LEN*8-1:0] win_shifted;

  assign byte_ready  = (state_q == S_FILL) || (state_q == S_SHIFT) || (state_q == S_DRAIN);
  assign xfer        = byte_valid && byte_ready;
  assign rx_inc      = rx_q + LEN_W'(1);
  assign win_shifted = {win_q[STR_LEN*8-9:0], byte_data};

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    win_d     = win_q;
    match_d   = match_q;
    off_d     = off_q;
    md5_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tgt_d   = target_hash;
          cnt_d   = byte_count;
          rx_d    = '0;
          win_d   = '0;
          match_d = 1'b0;
          off_d   = '0;
          state_d = (byte_count == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (xfer) begin
          win_d = win_shifted;
          rx_d  = rx_inc;
          // A full window takes priority; a short block ends once all its bytes are in.
          if (rx_inc == WIN_LEN)    state_d = S_ISSUE;
          else if (rx_inc == cnt_q) state_d = S_DONE;
        end
      end
      S_ISSUE: begin
        if (!md5_busy) begin
          md5_start = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (md5_done) begin
          if (md5_digest == tgt_q) begin
            match_d = 1'b1;
            off_d   = rx_q - WIN_LEN;
            state_d = (rx_q == cnt_q) ? S_DONE : S_DRAIN;
          end else begin
            state_d = (rx_q == cnt_q) ? S_DONE : S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (xfer) begin
          win_d   = win_shifted;
          rx_d    = rx_inc;
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (xfer) begin
          rx_d = rx_inc;
          if (rx_inc == cnt_q) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      rx_q    <= '0;
      win_q   <= '0;
      match_q <= 1'b0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      win_q   <= win_d;
      match_q <= match_d;
      off_q   <= off_d;
    end
  end

  assign md5_msg      = win_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign match        = match_q;
  assign match_offset = off_q;

endmodule

// File: tb/tb_md5_window_scheduler.sv
// Scoreboard bench for md5_window_scheduler: a behavioural md5 core answers each
// md5_start, and a monitor checks windows and block results against queued expectations.
module tb_md5_window_scheduler;
  localparam int STR_LEN = 19;
  localparam int LEN_W   = 16;
  localparam int LAT     = 3;
  localparam logic [127:0] KEY_HASH = 128'h1d5468d37f38dc34dca0692c3a6f2c83;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [127:0]         target_hash = '0;
  logic                 start = 1'b0;
  logic [LEN_W-1:0]     byte_count = '0;
  logic                 byte_valid = 1'b0;
  logic [7:0]           byte_data = '0;
  logic                 byte_ready;
  logic                 md5_start;
  logic [STR_LEN*8-1:0] md5_msg;
  logic                 md5_busy;
  logic                 md5_done = 1'b0;
  logic [127:0]         md5_digest = '0;
  logic                 busy, done, match;
  logic [LEN_W-1:0]     match_offset;

  md5_window_scheduler #(.STR_LEN(STR_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .target_hash(target_hash), .start(start),
    .byte_count(byte_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .md5_start(md5_start), .md5_msg(md5_msg),
    .md5_busy(md5_busy), .md5_done(md5_done), .md5_digest(md5_digest),
    .busy(busy), .done(done), .match(match), .match_offset(match_offset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             m;
    logic [LEN_W-1:0] off;
    int               ns;
    int               na;
  } res_t;

  res_t                 exp_res[$];
  logic [STR_LEN*8-1:0] exp_msg[$];
  logic [7:0]           dbuf[0:255];
  int                   ncmp = 0, nerr = 0;
  int                   nstart = 0, nacc = 0;
  bit                   blk_done = 0;
  logic                 hold_busy = 1'b0;
  bit                   inflight = 0;
  bit                   prev_done = 0;
  logic [STR_LEN*8-1:0] held = '0;
  logic [STR_LEN*8-1:0] key_msg = '0;
  logic [STR_LEN*8-1:0] core_m = '0;
  string                txt, key;

  assign md5_busy = hold_busy;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    ncmp++;
    nerr++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Behavioural md5 core: digest is the real hash only for the key string.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && md5_start) begin
        core_m = md5_msg;
        repeat (LAT) @(posedge clk);
        #1;
        md5_digest = (core_m == key_msg) ? KEY_HASH : (core_m[127:0] ^ 128'h5a5a_a5a5_0f0f_f0f0_1234_5678_9abc_def0);
        md5_done = 1'b1;
        @(posedge clk);
        #1;
        md5_done = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a window or a block result.
  initial begin
    res_t r;
    logic [STR_LEN*8-1:0] em;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        inflight  = 0;
        prev_done = 0;
      end else begin
        if (byte_valid && byte_ready) nacc++;
        if (md5_start) begin
          chk("start_while_core_busy", md5_busy, 0);
          nstart++;
          if (exp_msg.size() == 0) fail_now("unexpected_md5_start");
          else begin
            em = exp_msg.pop_front();
            chk("md5_msg", md5_msg, em);
          end
          inflight = 1;
          held = md5_msg;
        end
        if (md5_done && inflight) begin
          chk("msg_stable", md5_msg, held);
          inflight = 0;
        end
        if (done && prev_done) fail_now("done_not_pulse");
        if (done) begin
          if (exp_res.size() == 0) fail_now("unexpected_done");
          else begin
            r = exp_res.pop_front();
            chk("match", match, r.m);
            chk("match_offset", match_offset, r.off);
            chk("md5_start_count", nstart, r.ns);
            chk("bytes_accepted", nacc, r.na);
          end
          blk_done = 1;
        end
        prev_done = done;
      end
    end
  end

  task automatic load_text();
    for (int i = 0; i < 256; i++) dbuf[i] = (i < txt.len()) ? txt[i] : 8'h2e;
  endtask

  task automatic put_key(input int pos);
    for (int b = 0; b < STR_LEN; b++) dbuf[pos+b] = key[b];
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_byte_ready"}, byte_ready, 0);
    chk({tag, "_md5_start"}, md5_start, 0);
    chk({tag, "_md5_msg"}, md5_msg, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_match_offset"}, match_offset, 0);
  endtask

  task automatic run_block(input int cnt, input logic [127:0] tgt, input bit em, input int eoff,
                           input int ens, input int gap, input int bhold, input bit istart);
    logic [STR_LEN*8-1:0] m;
    int i, t;
    for (int w = 0; w < ens; w++) begin
      m = '0;
      for (int b = 0; b < STR_LEN; b++) m = {m[STR_LEN*8-9:0], dbuf[w+b]};
      exp_msg.push_back(m);
    end
    exp_res.push_back('{m: em, off: LEN_W'(eoff), ns: ens, na: cnt});
    nstart = 0;
    nacc = 0;
    blk_done = 0;
    hold_busy = (bhold > 0);
    @(posedge clk); #1;
    start = 1'b1;
    byte_count = cnt[LEN_W-1:0];
    target_hash = tgt;
    @(posedge clk); #1;
    start = 1'b0;
    byte_count = '1;
    target_hash = ~tgt;
    chk("busy_after_start", busy, 1);
    fork
      begin
        i = 0;
        t = 0;
        while (!blk_done && t < 4000) begin
          byte_valid = ($urandom_range(99) >= gap);
          byte_data = dbuf[i];
          if (byte_valid && byte_ready) i++;
          @(posedge clk); #1;
          t++;
        end
        byte_valid = 1'b0;
        if (!blk_done) fail_now("block_timeout");
      end
      begin
        if (bhold > 0) begin
          repeat (bhold) @(posedge clk);
          #1;
          hold_busy = 1'b0;
        end
      end
      begin
        if (istart) begin
          repeat (6) @(posedge clk);
          #1;
          start = 1'b1;
          byte_count = 16'd5;
          target_hash = 128'h0;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("busy_cleared", busy, 0);
  endtask

  initial begin
    int i, t;
    #500000;
    $display("FAIL global_watchdog (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i, t;
    txt = "ALICE'S ADVENTURES IN WONDERLAND Lewis Carroll THE MILLENNIUM FULCRUM EDITION 3.0 CHAPTER I Down the Rabbit-Hole Alice was beginning to get very tired";
    key = "\nAlice's Adventures";
    for (int b = 0; b < STR_LEN; b++) key_msg = {key_msg[STR_LEN*8-9:0], key[b]};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;

    // Reset mid-WAIT, then a stale md5_done must be ignored.
    load_text();
    put_key(0);
    exp_msg.push_back(key_msg);
    nstart = 0;
    nacc = 0;
    @(posedge clk); #1;
    start = 1'b1;
    byte_count = 16'd40;
    target_hash = KEY_HASH;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    t = 0;
    while (nstart == 0 && t < 200) begin
      byte_valid = 1'b1;
      byte_data = dbuf[i];
      if (byte_ready) i++;
      @(posedge clk); #1;
      t++;
    end
    if (nstart == 0) fail_now("reset_test_no_issue");
    byte_valid = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("abort");
    reset_n = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("match_after_stale_done", match, 0);
    chk("busy_after_abort", busy, 0);
    byte_valid = 1'b0;
    exp_msg.delete();
    exp_res.delete();

    // Match at byte 5 of a 100-byte block.
    load_text();
    put_key(5);
    run_block(100, KEY_HASH, 1, 5, 6, 0, 0, 0);

    // No match across 100 bytes.
    load_text();
    run_block(100, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 0, 0, 82, 20, 0, 0);

    // Short blocks.
    load_text();
    run_block(0, KEY_HASH, 0, 0, 0, 0, 0, 0);
    run_block(18, KEY_HASH, 0, 0, 0, 0, 0, 0);
    run_block(19, KEY_HASH, 0, 0, 1, 0, 0, 0);

    // Core backpressure with random byte gaps.
    load_text();
    run_block(30, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 0, 12, 40, 50, 0);

    // Ignored start mid-block; match lands on the final window.
    load_text();
    put_key(21);
    run_block(40, KEY_HASH, 1, 21, 22, 10, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/md5_window_scheduler.md
# md5_window_scheduler

Sequences the MD5 match datapath for one SEND_TEXT block. Accepts the block's text bytes from the command parser and keeps a sliding window of STR_LEN bytes. It issues every window position to a single md5 core, compares each digest against the target hash, and reports the first matching byte offset. It sits between cmd_parser (byte stream, target hash, block length) and md5core (start/busy/done handshake).

## Interface
- STR_LEN, 19, window length in bytes (length of each hashed candidate string)
- LEN_W, 16, width of block byte count and offsets

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- target_hash  in  128  digest to match; sampled on start
- start  in  1  one-cycle pulse; begins a block; ignored unless idle
- byte_count  in  LEN_W  number of bytes in the block; sampled on start
- byte_valid  in  1  text byte available
- byte_data  in  8  text byte
- byte_ready  out  1  scheduler accepts byte_data this cycle
- md5_start  out  1  one-cycle pulse; md5_msg is valid
- md5_msg  out  STR_LEN*8  candidate string; oldest byte in [STR_LEN*8-1 -: 8]
- md5_busy  in  1  core cannot accept md5_start
- md5_done  in  1  one-cycle pulse; md5_digest is valid
- md5_digest  in  128  core result
- busy  out  1  block in progress
- done  out  1  one-cycle pulse at end of block
- match  out  1  a window matched in the last block; sticky until next start
- match_offset  out  LEN_W  offset of the first byte of the matching window within the block

## Operation
- A byte transfers on a clk edge where byte_valid && byte_ready. Each new byte enters the window at [7:0] and the window shifts left by 8.
- FSM states: IDLE, FILL, ISSUE, WAIT, SHIFT, DRAIN, DONE.
- IDLE: on start, latch target_hash and byte_count, clear the window, rx counter, match and match_offset, then set busy. If byte_count==0, go to DONE. Otherwise go to FILL.
- FILL: byte_ready=1. After STR_LEN bytes are received, go to ISSUE. If byte_count<STR_LEN, all bytes are accepted and then the FSM goes to DONE with no hash issued.
- ISSUE: when !md5_busy, pulse md5_start and go to WAIT. Otherwise hold.
- WAIT: on md5_done, compare md5_digest with target_hash.
  - Equal: match<=1, match_offset<=rx_count-STR_LEN. Go to DRAIN, or to DONE if rx_count==byte_count.
  - Not equal: go to SHIFT, or to DONE if rx_count==byte_count.
- SHIFT: byte_ready=1. Accept one byte, then go to ISSUE.
- DRAIN: byte_ready=1. Discard bytes until rx_count==byte_count, then go to DONE. The parser stream must always complete.
- DONE: pulse done, clear busy, return to IDLE.
- Hashes per block: max(0, byte_count-STR_LEN+1) if no match. Hashing stops after the first match.
- The window does not carry over between blocks; a string spanning two blocks is not detected.
- Offsets and counters are LEN_W unsigned. rx_count never exceeds byte_count.

## Timing
- Reset values: byte_ready=0, md5_start=0, md5_msg=0, busy=0, done=0, match=0, match_offset=0; FSM in IDLE.
- start to busy=1: 1 cycle. byte_ready rises the cycle after start.
- The last byte of a window is accepted at edge N. md5_start is asserted in cycle N+1 if md5_busy=0.
- md5_msg is stable from md5_start until md5_done. md5_done outside WAIT is ignored.
- Compare is combinational on md5_digest in the md5_done cycle. match and match_offset update on that edge.
- done pulses one cycle after the final byte is accepted or the final md5_done, whichever is later. match and match_offset are valid from the done cycle until the next start.
- start while busy=1 is ignored. start and done in the same cycle cannot occur, because start is only accepted in IDLE.
- reset_n low mid-block aborts immediately to reset values. An in-flight md5_done after reset is ignored.

## Test plan
- Reset: assert reset_n=0 mid-WAIT with byte_valid high → next cycle all outputs are 0 and byte_ready=0. A following md5_done pulse does not change match.
- Match: target 1d5468d37f38dc34dca0692c3a6f2c83, 100-byte block with "\nAlice's Adventures" at byte 5 → exactly 6 md5_start pulses, match=1, match_offset=5, all 100 bytes consumed, then one done pulse.
- No match: 100 bytes of alice30.txt from offset 0 with a different target → 82 md5_start pulses, match=0, done pulses once.
- Short blocks: byte_count=0 → done with no bytes accepted. byte_count=18 → 18 bytes accepted and no md5_start. byte_count=19 → exactly 1 md5_start.
- Backpressure: hold md5_busy=1 for 50 cycles in ISSUE and toggle byte_valid randomly → md5_start waits for md5_busy=0, and md5_msg bytes equal the stream bytes in order.
- Ignored start: pulse start while busy → byte_count and target_hash are unchanged and the block completes normally.
